spi_master_shifter: RTL and testbench
=====================================

// Module: spi_master_shifter
// PURPOSE
//  SPI master shift engine, mode 0 (CPOL=0, CPHA=0), MSB first, 8- or 16-bit frames.
//  Sits directly downstream of the peripherals register block, which drives its start,
//  width and transmit word and reads back busy and the received word. Owns SCLK, MOSI and
//  CS_N timing; the CPU never touches the pins.
// PARAMETERS
//  CLOCK_DIV  4  raw_clk cycles per SCLK half-period (legal range 1..255).
// PORTS
//  raw_clk   in   1   single clock; all state changes on its rising edge
//  reset_n   in   1   asynchronous, active-low reset
//  start     in   1   level request; a frame is accepted only in IDLE
//  width_16  in   1   1 = 16-bit frame, 0 = 8-bit frame (uses data_tx[7:0])
//  data_tx   in   16  transmit word
//  data_rx   out  16  last received word, zero-extended for 8-bit frames
//  busy      out  1   high while a frame is in progress
//  done      out  1   one-cycle pulse when data_rx updates
//  sclk      out  1   SPI clock, idle low
//  mosi      out  1   SPI data out
//  miso      in   1   SPI data in
//  cs_n      out  1   chip select, active low
// BEHAVIOUR
//  - Reset (asynchronous, any state): state=IDLE, busy=0, done=0, sclk=0, mosi=0, cs_n=1,
//    data_rx=0, divider and bit counters=0. A frame in progress is abandoned; no done pulse.
//  - States: IDLE, SETUP, HIGH, LOW, DONE, REARM.
//  - IDLE: on an edge with start=1, data_tx and width_16 latch into the shift register and
//    width flop, N=16 or 8. Next cycle: busy=1, cs_n=0, mosi=MSB of the frame -> SETUP.
//  - SETUP: hold for CLOCK_DIV cycles, then -> HIGH.
//  - HIGH: on entry sclk=1 and miso is sampled into the shift LSB. Hold CLOCK_DIV cycles,
//    then -> LOW.
//  - LOW: on entry sclk=0 and the shift register moves left. If bits remain, mosi takes the
//    next bit. Hold CLOCK_DIV cycles. If bits remain, -> HIGH; after bit N, -> DONE.
//  - DONE (1 cycle): data_rx is loaded (8-bit frames give {8'h00, rx[7:0]}), done=1,
//    busy=0, cs_n=1, mosi=0 -> REARM.
//  - REARM: stay here while start=1, then -> IDLE. A held start never retriggers a frame.
//  - Frame length, busy high: CLOCK_DIV*(1+2N) cycles. With the default, 8-bit = 68 cycles
//    and 16-bit = 132 cycles.
//  - Changes to data_tx, width_16 or start during a frame are ignored. data_rx holds its
//    value until the next DONE.
//  - The divider counter counts 0..CLOCK_DIV-1 and wraps. The bit counter is 5 bits wide and
//    never exceeds 16. With CLOCK_DIV=1, SCLK toggles every raw_clk cycle.
// STRUCTURE
//  - spi_defs.vh (shared include): state encodings, SPI_WIDTH_8/16 constants and the
//    CLOCK_DIV default. The peripherals block uses the same file for its width bit.
//  - One sub-module, spi_half_tick: the CLOCK_DIV counter. It emits a one-cycle tick at each
//    half-period end and is cleared whenever the FSM is in IDLE.
//  - The FSM, shift register and output flops live in this module. All outputs are
//    registered (no combinational path from inputs to pins).
// TESTING
//  1. Loopback 8-bit: miso=mosi, data_tx=16'h12A5, width_16=0, start pulse.
//     -> 8 sclk rising edges, mosi stream 1010_0101, busy for 68 cycles,
//     data_rx=16'h00A5, done pulses once.
//  2. 16-bit, miso tied 1, data_tx=16'hC3E1.
//     -> mosi stream 1100_0011_1110_0001, 16 sclk rises, data_rx=16'hFFFF,
//     busy for 132 cycles.
//  3. start held high through the end of a frame.
//     -> exactly one frame, cs_n stays 1 until start falls. start falling then rising
//     again -> a second frame.
//  4. data_tx changed to 16'h0000 and width_16 toggled mid-frame.
//     -> mosi stream and frame length match the values latched at start.
//  5. reset_n pulled low after 3 bits.
//     -> sclk=0, cs_n=1, busy=0, data_rx=0 in the same cycle, no done pulse, IDLE after
//     release.
//  6. CLOCK_DIV=1, loopback 16'h5A3C, 16-bit.
//     -> sclk period of 2 cycles, busy for 33 cycles, data_rx=16'h5A3C.

Source files
------------

// File: rtl/spi_master_shifter_pkg.sv
// Shared definitions for the SPI master shift engine: FSM states, frame-width
// codes and the default SCLK half-period divider.
package spi_master_shifter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_DONE  = 3'd4,
    ST_REARM = 3'd5
  } spi_state_t;

  localparam logic SPI_WIDTH_8  = 1'b0;
  localparam logic SPI_WIDTH_16 = 1'b1;

  localparam int unsigned SPI_CLOCK_DIV_DEFAULT = 4;

  function automatic logic [4:0] frame_bits(input logic width);
    return (width == SPI_WIDTH_16) ? 5'd16 : 5'd8;
  endfunction

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period divider: one-cycle tick after every CLOCK_DIV raw_clk cycles,
// held at zero while the engine is idle.
module spi_half_tick #(
  parameter int unsigned CLOCK_DIV = 4
) (
  input  logic raw_clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(CLOCK_DIV - 1);

  logic [7:0] count;

  assign tick = !clear && (count == LAST);

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/spi_master_shifter.sv
// SPI master shift engine, mode 0, MSB first, 8- or 16-bit frames.
// Owns SCLK/MOSI/CS_N timing; every output is a flop.
module spi_master_shifter
  import spi_master_shifter_pkg::*;
#(
  parameter int unsigned CLOCK_DIV = SPI_CLOCK_DIV_DEFAULT
) (
  input  logic        raw_clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        width_16,
  input  logic [15:0] data_tx,
  output logic [15:0] data_rx,
  output logic        busy,
  output logic        done,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  spi_state_t  state, state_next;
  logic        tick;
  logic        width_q;
  logic        sample;
  logic [15:0] shift;
  logic [4:0]  bit_cnt;

  spi_half_tick #(.CLOCK_DIV(CLOCK_DIV)) u_half_tick (
    .raw_clk (raw_clk),
    .reset_n (reset_n),
    .clear   (state == ST_IDLE),
    .tick    (tick)
  );

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start) state_next = ST_SETUP;
      ST_SETUP: if (tick)  state_next = ST_HIGH;
      ST_HIGH:  if (tick)  state_next = ST_LOW;
      ST_LOW:   if (tick)  state_next = (bit_cnt == frame_bits(width_q)) ? ST_DONE : ST_HIGH;
      ST_DONE:             state_next = ST_REARM;
      ST_REARM: if (!start) state_next = ST_IDLE;
      default:             state_next = ST_IDLE;
    endcase
  end

  // miso is captured into a one-bit holding flop on the rising SCLK edge and
  // enters the shift LSB on the falling edge, so the unsent transmit bits in
  // the low end of the register are never overwritten before they go out.
  // 8-bit frames are left-justified so the MSB always sits at shift[15].
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      data_rx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      width_q <= SPI_WIDTH_8;
      sample  <= 1'b0;
      shift   <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          width_q <= width_16;
          shift   <= (width_16 == SPI_WIDTH_8) ? {data_tx[7:0], 8'h00} : data_tx;
          mosi    <= (width_16 == SPI_WIDTH_8) ? data_tx[7] : data_tx[15];
          bit_cnt <= '0;
          busy    <= 1'b1;
          cs_n    <= 1'b0;
        end
        ST_SETUP: if (tick) begin
          sclk   <= 1'b1;
          sample <= miso;
        end
        ST_HIGH: if (tick) begin
          sclk    <= 1'b0;
          shift   <= {shift[14:0], sample};
          bit_cnt <= bit_cnt + 5'd1;
          if ((bit_cnt + 5'd1) < frame_bits(width_q)) mosi <= shift[14];
        end
        ST_LOW: if (tick) begin
          if (bit_cnt == frame_bits(width_q)) begin
            data_rx <= (width_q == SPI_WIDTH_16) ? shift : {8'h00, shift[7:0]};
            done    <= 1'b1;
            busy    <= 1'b0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
          end else begin
            sclk   <= 1'b1;
            sample <= miso;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Self-checking bench for spi_master_shifter: directed table, random frames
// against a frame-level reference model, and hand-written corner sequences.
module tb_spi_master_shifter;

  logic        raw_clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        width_16;
  logic [15:0] data_tx;
  logic        loopback;
  logic        miso_drv;
  logic        sel;

  logic [15:0] data_rx0, data_rx1;
  logic        busy0, busy1, done0, done1, sclk0, sclk1, mosi0, mosi1, cs_n0, cs_n1;
  logic        miso0, miso1;

  int tests    = 0;
  int failures = 0;

  always #5 raw_clk = ~raw_clk;

  assign miso0 = loopback ? mosi0 : miso_drv;
  assign miso1 = loopback ? mosi1 : miso_drv;

  spi_master_shifter dut_div4 (
    .raw_clk(raw_clk), .reset_n(reset_n), .start(start), .width_16(width_16),
    .data_tx(data_tx), .data_rx(data_rx0), .busy(busy0), .done(done0),
    .sclk(sclk0), .mosi(mosi0), .miso(miso0), .cs_n(cs_n0)
  );

  spi_master_shifter #(.CLOCK_DIV(1)) dut_div1 (
    .raw_clk(raw_clk), .reset_n(reset_n), .start(start), .width_16(width_16),
    .data_tx(data_tx), .data_rx(data_rx1), .busy(busy1), .done(done1),
    .sclk(sclk1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1)
  );

  logic [15:0] o_rx;
  logic        o_busy, o_done, o_sclk, o_mosi, o_cs_n;
  assign o_rx   = sel ? data_rx1 : data_rx0;
  assign o_busy = sel ? busy1 : busy0;
  assign o_done = sel ? done1 : done0;
  assign o_sclk = sel ? sclk1 : sclk0;
  assign o_mosi = sel ? mosi1 : mosi0;
  assign o_cs_n = sel ? cs_n1 : cs_n0;

  typedef struct {
    logic [15:0] tx;
    logic        w16;
    logic        loop;
    logic [15:0] pat;
    logic        perturb;
    logic        sel;
    logic [15:0] exp_rx;
    int unsigned exp_len;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: a frame sends tx MSB first, returns the sampled miso bits MSB
  // first, and keeps busy high for div*(1+2N) cycles.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int unsigned n   = v.w16 ? 16 : 8;
    int unsigned div = v.sel ? 1 : 4;
    logic [15:0] src = v.loop ? v.tx : v.pat;
    r.exp_rx  = v.w16 ? src : {8'h00, src[7:0]};
    r.exp_len = div * (1 + 2 * n);
    return r;
  endfunction

  task automatic wait_idle();
    int unsigned k = 0;
    while ((busy0 || busy1) && k < 400) begin
      @(negedge raw_clk);
      k++;
    end
    check("both idle", {30'd0, busy1, busy0}, 32'd0);
    repeat (3) @(negedge raw_clk);
  endtask

  task automatic run_frame(input vec_t v, input string name);
    int unsigned n, div, cyc, rises, busy_cyc, dones, last_rise, bad_period, cs_err;
    logic [15:0] cap, exp_mosi, got_rx;
    logic        prev_sclk, seen, mosi_end, cs_end;
    n = v.w16 ? 16 : 8;
    div = v.sel ? 1 : 4;
    exp_mosi = v.w16 ? v.tx : {8'h00, v.tx[7:0]};
    cyc = 0; rises = 0; busy_cyc = 0; dones = 0; last_rise = 0; bad_period = 0; cs_err = 0;
    cap = '0; got_rx = '0; prev_sclk = 1'b0; seen = 1'b0; mosi_end = 1'b1; cs_end = 1'b0;
    sel = v.sel;
    @(negedge raw_clk);
    data_tx = v.tx; width_16 = v.w16; loopback = v.loop; miso_drv = v.pat[n-1]; start = 1'b1;
    @(negedge raw_clk);
    start = 1'b0;
    while (!seen && cyc < 1000) begin
      if (o_busy) busy_cyc++;
      if (o_cs_n === o_busy) cs_err++;
      if (o_sclk && !prev_sclk) begin
        cap = {cap[14:0], o_mosi};
        if (rises != 0 && (cyc - last_rise) != 2 * div) bad_period++;
        last_rise = cyc;
        rises++;
      end
      prev_sclk = o_sclk;
      if (o_done) begin
        dones++; seen = 1'b1; got_rx = o_rx; mosi_end = o_mosi; cs_end = o_cs_n;
      end
      if (v.perturb && cyc == 20) begin
        data_tx = '0;
        width_16 = ~v.w16;
      end
      if (rises < n) miso_drv = v.pat[n-1-rises];
      @(negedge raw_clk);
      cyc++;
    end
    check({name, " done seen"}, {31'd0, seen}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      if (o_done) dones++;
      @(negedge raw_clk);
    end
    check({name, " rx"}, {16'd0, got_rx}, {16'd0, v.exp_rx});
    check({name, " rx held"}, {16'd0, o_rx}, {16'd0, v.exp_rx});
    check({name, " mosi stream"}, {16'd0, cap}, {16'd0, exp_mosi});
    check({name, " sclk rises"}, rises, n);
    check({name, " busy cycles"}, busy_cyc, v.exp_len);
    check({name, " done pulses"}, dones, 1);
    check({name, " sclk period"}, bad_period, 0);
    check({name, " cs_n vs busy"}, cs_err, 0);
    check({name, " end pins"}, {30'd0, mosi_end, cs_end}, 32'd1);
    wait_idle();
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v;
    int unsigned cyc, frames, cs_low, rises, bad;
    logic seen, prev;

    tbl[0] = '{16'h12A5, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h00A5, 68};
    tbl[1] = '{16'hC3E1, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 16'hFFFF, 132};
    tbl[2] = '{16'hA55A, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h005A, 68};
    tbl[3] = '{16'h9C31, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 16'h9C31, 132};
    tbl[4] = '{16'h5A3C, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h5A3C, 33};
    tbl[5] = '{16'h00FF, 1'b0, 1'b0, 16'h003C, 1'b0, 1'b0, 16'h003C, 68};
    tbl[6] = '{16'h0081, 1'b0, 1'b0, 16'h00C6, 1'b0, 1'b1, 16'h00C6, 17};

    reset_n = 1'b0; start = 1'b0; width_16 = 1'b0; data_tx = '0;
    loopback = 1'b1; miso_drv = 1'b0; sel = 1'b0;
    repeat (3) @(negedge raw_clk);
    check("reset div4 pins", {busy0, done0, sclk0, mosi0, cs_n0}, 5'b00001);
    check("reset div4 rx", {16'd0, data_rx0}, 32'd0);
    check("reset div1 pins", {busy1, done1, sclk1, mosi1, cs_n1}, 5'b00001);
    reset_n = 1'b1;
    repeat (2) @(negedge raw_clk);

    for (int i = 0; i < 7; i++) run_frame(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      v.tx = 16'($urandom); v.w16 = 1'($urandom_range(0, 1));
      v.loop = 1'($urandom_range(0, 1)); v.pat = 16'($urandom);
      v.perturb = 1'($urandom_range(0, 1)); v.sel = 1'($urandom_range(0, 1));
      run_frame(model(v), $sformatf("rand%0d", i));
    end

    // Held start: one frame only, then no retrigger until start drops.
    sel = 1'b0;
    @(negedge raw_clk);
    data_tx = 16'h00C3; width_16 = 1'b0; loopback = 1'b1; start = 1'b1;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 1000) begin
      if (done0) seen = 1'b1;
      @(negedge raw_clk);
      cyc++;
    end
    check("held done seen", {31'd0, seen}, 32'd1);
    frames = 0; cs_low = 0; prev = busy0;
    for (int i = 0; i < 40; i++) begin
      if (busy0 && !prev) frames++;
      if (!cs_n0) cs_low++;
      prev = busy0;
      @(negedge raw_clk);
    end
    check("held no retrigger", frames, 0);
    check("held cs_n high", cs_low, 0);
    check("held rx", {16'd0, data_rx0}, 32'h00C3);
    start = 1'b0;
    wait_idle();
    v = '{16'h003C, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 0};
    run_frame(model(v), "rearm second");

    // Reset mid-frame after three bits.
    sel = 1'b0;
    @(negedge raw_clk);
    data_tx = 16'hF0F0; width_16 = 1'b1; loopback = 1'b1; start = 1'b1;
    @(negedge raw_clk);
    start = 1'b0;
    rises = 0; prev = 1'b0; cyc = 0;
    while (rises < 3 && cyc < 1000) begin
      if (sclk0 && !prev) rises++;
      prev = sclk0;
      @(negedge raw_clk);
      cyc++;
    end
    check("rst reach bit3", rises, 3);
    repeat (2) @(negedge raw_clk);
    reset_n = 1'b0;
    #1;
    check("rst async pins", {busy0, done0, sclk0, cs_n0}, 4'b0001);
    check("rst async rx", {16'd0, data_rx0}, 32'd0);
    @(negedge raw_clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (done0 || busy0 || !cs_n0 || sclk0) bad++;
      @(negedge raw_clk);
    end
    check("rst stays idle", bad, 0);
    v = '{16'h5A3C, 1'b1, 1'b0, 16'h1E87, 1'b0, 1'b0, 16'h0000, 0};
    run_frame(model(v), "post reset");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
